bsg_gateway_clk_gen: RTL and testbench



---
 rtl/bsg_gateway_clk_pkg.sv | 10 +
 rtl/bsg_gateway_clk_div_chan.sv | 106 ++++++++++
 rtl/bsg_gateway_clk_gen.sv | 59 +++++
 tb/tb_bsg_gateway_clk_gen.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_gateway_clk_pkg.sv
// Shared types for the gateway clock generator: per-channel divider state.
package bsg_gateway_clk_pkg;

    typedef enum logic [1:0] {
        CHAN_RUN  = 2'd0,
        CHAN_PEND = 2'd1,
        CHAN_STOP = 2'd2
    } chan_state_e;

endpackage

// File: rtl/bsg_gateway_clk_div_chan.sv
// One divided-clock channel: registered output toggling every d+1 master cycles,
// with divisor updates and stop/start applied only at the end of a high half-period.
module bsg_gateway_clk_div_chan
    import bsg_gateway_clk_pkg::*;
#(
    parameter int width_p     = 8,
    parameter int reset_div_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               accept_i,
    input  logic [width_p-1:0] div_i,
    output logic               clk_o,
    output logic               stopped_o,
    output logic               pending_o
);

    localparam logic [width_p-1:0] reset_div_lp = width_p'(reset_div_p);

    chan_state_e        state_q, state_d;
    logic [width_p-1:0] d_q, d_d;
    logic [width_p-1:0] pend_div_q, pend_div_d;
    logic               pend_q, pend_d;
    logic [width_p-1:0] cnt_q, cnt_d;
    logic               o_q, o_d;
    logic               apply;
    logic               halt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= CHAN_RUN;
            d_q        <= reset_div_lp;
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            o_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            o_q        <= o_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        o_d        = o_q;
        apply      = 1'b0;
        halt       = 1'b0;

        case (state_q)
            CHAN_STOP: begin
                cnt_d = '0;
                o_d   = 1'b0;
                apply = pend_q;
                halt  = !en_i;
            end
            default: begin
                if (cnt_q == d_q) begin
                    cnt_d = '0;
                    if (o_q) begin
                        o_d   = 1'b0;
                        apply = pend_q;
                        halt  = !en_i;
                    end else if (en_i) begin
                        o_d = 1'b1;
                    end else begin
                        // Low half already complete: park without raising the clock.
                        apply = pend_q;
                        halt  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + width_p'(1);
                end
            end
        endcase

        if (apply) begin
            d_d    = pend_div_q;
            pend_d = 1'b0;
        end
        if (accept_i) begin
            pend_div_d = div_i;
            pend_d     = 1'b1;
        end

        if (halt)
            state_d = CHAN_STOP;
        else
            state_d = pend_d ? CHAN_PEND : CHAN_RUN;
    end

    always_comb begin
        clk_o     = o_q;
        stopped_o = (state_q == CHAN_STOP);
        pending_o = pend_q;
    end

endmodule

// File: rtl/bsg_gateway_clk_gen.sv
// Gateway-side core/IO clock generator: two independent divider channels sharing
// one divisor-pair handshake.
module bsg_gateway_clk_gen
    import bsg_gateway_clk_pkg::*;
#(
    parameter int width_p          = 8,
    parameter int core_reset_div_p = 1,
    parameter int io_reset_div_p   = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] core_div_i,
    input  logic [width_p-1:0] io_div_i,
    input  logic               div_v_i,
    output logic               div_ready_o,
    input  logic               clk_en_i,
    output logic               core_clk_o,
    output logic               io_clk_o,
    output logic               core_stopped_o,
    output logic               io_stopped_o
);

    logic core_pending;
    logic io_pending;
    logic accept;

    // A new pair waits until both channels have consumed the previous one.
    assign div_ready_o = !core_pending && !io_pending;
    assign accept      = div_v_i && div_ready_o;

    bsg_gateway_clk_div_chan #(
        .width_p    (width_p),
        .reset_div_p(core_reset_div_p)
    ) core_chan (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .en_i     (clk_en_i),
        .accept_i (accept),
        .div_i    (core_div_i),
        .clk_o    (core_clk_o),
        .stopped_o(core_stopped_o),
        .pending_o(core_pending)
    );

    bsg_gateway_clk_div_chan #(
        .width_p    (width_p),
        .reset_div_p(io_reset_div_p)
    ) io_chan (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .en_i     (clk_en_i),
        .accept_i (accept),
        .div_i    (io_div_i),
        .clk_o    (io_clk_o),
        .stopped_o(io_stopped_o),
        .pending_o(io_pending)
    );

endmodule

// File: tb/tb_bsg_gateway_clk_gen.sv
// Bench for bsg_gateway_clk_gen: half-period countdown reference model checked every
// cycle, plus directed sequences and a table of divisor/period pairs.
module tb_bsg_gateway_clk_gen;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] core_div_i;
    logic [7:0] io_div_i;
    logic       div_v_i;
    logic       div_ready_o;
    logic       clk_en_i;
    logic       core_clk_o;
    logic       io_clk_o;
    logic       core_stopped_o;
    logic       io_stopped_o;

    int n_checks = 0;
    int n_fails  = 0;

    bsg_gateway_clk_gen dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .core_div_i    (core_div_i),
        .io_div_i      (io_div_i),
        .div_v_i       (div_v_i),
        .div_ready_o   (div_ready_o),
        .clk_en_i      (clk_en_i),
        .core_clk_o    (core_clk_o),
        .io_clk_o      (io_clk_o),
        .core_stopped_o(core_stopped_o),
        .io_stopped_o  (io_stopped_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: level, edges left in the current half, divisor, pending value.
    int  m_lvl  [2];
    int  m_left [2];
    int  m_div  [2];
    int  m_pq   [2];
    int  m_pv   [2];
    int  m_stop [2];
    int  n_accepts = 0;

    typedef struct {
        int core_div;
        int io_div;
        int core_per;
        int io_per;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_ready();
        return (m_pq[0] == 0 && m_pq[1] == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_lvl[c]  = 0;
            m_div[c]  = 1;
            m_left[c] = 2;
            m_pq[c]   = 0;
            m_pv[c]   = 0;
            m_stop[c] = 0;
        end
    endtask

    task automatic model_apply(input int c);
        if (m_pq[c] != 0) begin
            m_div[c] = m_pv[c];
            m_pq[c]  = 0;
        end
    endtask

    task automatic model_step();
        int acc;
        int nv[2];
        acc   = (div_v_i && model_ready() != 0) ? 1 : 0;
        nv[0] = int'(core_div_i);
        nv[1] = int'(io_div_i);
        for (int c = 0; c < 2; c++) begin
            if (m_stop[c] != 0) begin
                model_apply(c);
                if (clk_en_i) begin
                    m_stop[c] = 0;
                    m_left[c] = m_div[c] + 1;
                end
            end else begin
                m_left[c]--;
                if (m_left[c] == 0) begin
                    if (m_lvl[c] != 0) begin
                        m_lvl[c] = 0;
                        model_apply(c);
                        if (!clk_en_i) m_stop[c] = 1;
                    end else if (clk_en_i) begin
                        m_lvl[c] = 1;
                    end else begin
                        model_apply(c);
                        m_stop[c] = 1;
                    end
                    m_left[c] = m_div[c] + 1;
                end
            end
            if (acc != 0) begin
                m_pq[c] = 1;
                m_pv[c] = nv[c];
            end
        end
        if (acc != 0) n_accepts++;
    endtask

    task automatic compare_all();
        check("core_clk", int'(core_clk_o), m_lvl[0]);
        check("io_clk", int'(io_clk_o), m_lvl[1]);
        check("core_stopped", int'(core_stopped_o), m_stop[0]);
        check("io_stopped", int'(io_stopped_o), m_stop[1]);
        check("div_ready", int'(div_ready_o), model_ready());
    endtask

    // One master cycle: model updates at the edge, DUT compared on the falling edge.
    task automatic cycle();
        @(posedge clk_i);
        if (reset_i) model_reset();
        else model_step();
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (!div_ready_o && k < 600) begin
            cycle();
            k++;
        end
        check({name, "_ready_timeout"}, int'(div_ready_o), 1);
    endtask

    task automatic wait_high(input int c);
        int k = 0;
        while (((c == 0) ? core_clk_o : io_clk_o) == 1'b0 && k < 600) begin
            cycle();
            k++;
        end
        check("wait_high_timeout", int'((c == 0) ? core_clk_o : io_clk_o), 1);
    endtask

    task automatic measure(input int c, output int per);
        logic prev;
        int   k;
        int   rises;
        per   = 0;
        rises = 0;
        k     = 0;
        prev  = (c == 0) ? core_clk_o : io_clk_o;
        while (rises < 2 && k < 1200) begin
            cycle();
            k++;
            if (rises == 1) per++;
            if (!prev && ((c == 0) ? core_clk_o : io_clk_o)) rises++;
            prev = (c == 0) ? core_clk_o : io_clk_o;
        end
        if (rises < 2) per = -1;
    endtask

    task automatic accept_pair(input int cd, input int iod);
        core_div_i = 8'(cd);
        io_div_i   = 8'(iod);
        div_v_i    = 1'b1;
        cycle();
        div_v_i    = 1'b0;
    endtask

    initial begin
        int per;
        int acc0;

        vecs[0] = '{3, 0, 8, 2};
        vecs[1] = '{0, 5, 2, 12};
        vecs[2] = '{2, 2, 6, 6};
        vecs[3] = '{7, 1, 16, 4};
        vecs[4] = '{0, 0, 2, 2};

        reset_i    = 1'b1;
        core_div_i = '0;
        io_div_i   = '0;
        div_v_i    = 1'b0;
        clk_en_i   = 1'b1;
        model_reset();
        run(3);
        reset_i = 1'b0;
        #1;
        check("reset_core_clk", int'(core_clk_o), 0);
        check("reset_io_clk", int'(io_clk_o), 0);
        check("reset_ready", int'(div_ready_o), 1);
        check("reset_stopped", int'(core_stopped_o | io_stopped_o), 0);

        // First rise lands on the second edge after reset with the default divisor.
        cycle();
        check("first_rise_early", int'(core_clk_o), 0);
        cycle();
        check("first_rise_core", int'(core_clk_o), 1);
        check("first_rise_io", int'(io_clk_o), 1);
        measure(0, per);
        check("reset_core_period", per, 4);
        measure(1, per);
        check("reset_io_period", per, 4);

        // Update while running: ready drops until both channels apply.
        accept_pair(3, 0);
        check("ready_low_after_accept", int'(div_ready_o), 0);
        wait_ready("update");
        run(20);
        measure(0, per);
        check("update_core_period", per, 8);
        measure(1, per);
        check("update_io_period", per, 2);

        // Stop while high, then restart.
        wait_high(0);
        clk_en_i = 1'b0;
        run(30);
        check("stop_core", int'(core_stopped_o && !core_clk_o), 1);
        check("stop_io", int'(io_stopped_o && !io_clk_o), 1);
        clk_en_i = 1'b1;
        run(30);

        // Accept while stopped: loads directly, stays stopped.
        clk_en_i = 1'b0;
        run(30);
        accept_pair(2, 4);
        check("stopped_accept_ready_low", int'(div_ready_o), 0);
        cycle();
        check("stopped_accept_ready_back", int'(div_ready_o), 1);
        check("stopped_accept_still_stopped", int'(core_stopped_o & io_stopped_o), 1);
        clk_en_i = 1'b1;
        measure(0, per);
        check("restart_core_period", per, 6);
        measure(1, per);
        check("restart_io_period", per, 10);

        // div_v held high across an update: one accept, next only after ready returns.
        acc0       = n_accepts;
        core_div_i = 8'd5;
        io_div_i   = 8'd1;
        div_v_i    = 1'b1;
        cycle();
        run(3);
        check("held_valid_single_accept", n_accepts - acc0, 1);
        wait_ready("held");
        cycle();
        div_v_i = 1'b0;
        check("held_valid_second_accept", n_accepts - acc0, 2);
        run(20);

        // Reset mid high pulse with an update pending.
        wait_ready("pre_reset");
        wait_high(0);
        accept_pair(9, 9);
        wait_high(0);
        @(posedge clk_i);
        model_step();
        #2;
        reset_i = 1'b1;
        model_reset();
        #1;
        check("async_reset_core", int'(core_clk_o), 0);
        check("async_reset_io", int'(io_clk_o), 0);
        check("async_reset_ready", int'(div_ready_o), 1);
        @(negedge clk_i);
        compare_all();
        reset_i = 1'b0;
        measure(0, per);
        check("post_reset_core_period", per, 4);

        // Table of divisor pairs and resulting periods.
        for (int v = 0; v < 5; v++) begin
            wait_ready("table");
            accept_pair(vecs[v].core_div, vecs[v].io_div);
            wait_ready("table_apply");
            run(40);
            measure(0, per);
            check($sformatf("table%0d_core_period", v), per, vecs[v].core_per);
            measure(1, per);
            check($sformatf("table%0d_io_period", v), per, vecs[v].io_per);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            div_v_i    = ($urandom_range(0, 3) == 0);
            core_div_i = 8'($urandom_range(0, 6));
            io_div_i   = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 24) == 0) clk_en_i = ~clk_en_i;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
